// File: rtl/led_mmio_writer_pkg.sv
// led_io_pkg: shared constants and types for the LED MMIO writer.
//   - CPU-visible addresses of the hex, decimal and status registers
//   - decimal range limit, overflow digit pattern, conversion width
//   - controller state type
package led_io_pkg;

    localparam logic [31:0] LED_HEX_ADDR  = 32'hFFFF_FC60;
    localparam logic [31:0] LED_DEC_ADDR  = 32'hFFFF_FC64;
    localparam logic [31:0] LED_STAT_ADDR = 32'hFFFF_FC68;

    localparam logic [31:0] DEC_MAX     = 32'd9999;
    localparam logic [15:0] ERR_PATTERN = 16'hEEEE;

    // 14 bits cover 0..9999
    localparam int unsigned CONV_BITS = 14;
    localparam int unsigned CNT_W     = $clog2(CONV_BITS);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } led_state_e;

endpackage

// File: rtl/led_mmio_writer_if.sv
// led_mmio_writer_if: CPU data-memory bus as seen by the LED MMIO slave.
//   mem_write : store strobe, one cycle per store
//   mem_read  : load strobe
//   addr      : byte address
//   wdata     : store data
//   rdata     : load data, driven combinationally by the slave
interface led_mmio_writer_if;

    logic        mem_write;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output mem_write,
        output mem_read,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  mem_write,
        input  mem_read,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/led_mmio_writer_bcd_dabble_step.sv
// bcd_dabble_step: one shift-add-3 iteration of binary-to-BCD conversion.
//   bcd      : current four BCD digits
//   bin_msb  : next binary bit shifted in at the bottom
//   bcd_next : digits after +3 correction and a left shift by one
module bcd_dabble_step (
    input  logic [15:0] bcd,
    input  logic        bin_msb,
    output logic [15:0] bcd_next
);

    logic [15:0] corr;

    always_comb begin
        corr = bcd;
        for (int unsigned d = 0; d < 4; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                corr[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
        bcd_next = {corr[14:0], bin_msb};
    end

endmodule

// File: rtl/led_mmio_writer.sv
// led_mmio_writer: memory-mapped bridge from CPU stores to the seven-segment
// scanner.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : CPU data bus (slave side); status readable at LED_STAT_ADDR
//   io_busy   : high while a decimal conversion is in progress
//   led_ctrl  : one-cycle load strobe to the scanner (registered)
//   led_wdata : digit word, digit3..digit0 = [15:12]..[3:0] (registered)
module led_mmio_writer
    import led_io_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    led_mmio_writer_if.slave     bus,
    output logic                 io_busy,
    output logic                 led_ctrl,
    output logic [15:0]          led_wdata
);

    led_state_e           state_q, state_d;
    logic [CONV_BITS-1:0] bin_q, bin_d;
    logic [15:0]          bcd_q, bcd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 led_ctrl_q, led_ctrl_d;
    logic [15:0]          led_wdata_q, led_wdata_d;

    logic [15:0]          bcd_step;
    logic                 hex_hit;
    logic                 dec_hit;

    bcd_dabble_step u_step (
        .bcd      (bcd_q),
        .bin_msb  (bin_q[CONV_BITS-1]),
        .bcd_next (bcd_step)
    );

    assign hex_hit = bus.mem_write && (bus.addr == LED_HEX_ADDR);
    assign dec_hit = bus.mem_write && (bus.addr == LED_DEC_ADDR);

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        led_ctrl_d  = 1'b0;
        led_wdata_d = led_wdata_q;

        case (state_q)
            IDLE: begin
                if (hex_hit) begin
                    led_wdata_d = bus.wdata[15:0];
                    led_ctrl_d  = 1'b1;
                end else if (dec_hit) begin
                    if (bus.wdata > DEC_MAX) begin
                        led_wdata_d = ERR_PATTERN;
                        led_ctrl_d  = 1'b1;
                        ovf_d       = 1'b1;
                    end else begin
                        bin_d   = bus.wdata[CONV_BITS-1:0];
                        bcd_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                bcd_d = bcd_step;
                bin_d = {bin_q[CONV_BITS-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                // Strobe is registered, so it is launched on the last
                // iteration to appear in the DONE cycle with the final digits.
                if (cnt_q == CNT_W'(CONV_BITS - 1)) begin
                    state_d     = DONE;
                    led_ctrl_d  = 1'b1;
                    led_wdata_d = bcd_step;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            led_ctrl_q  <= 1'b0;
            led_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            led_ctrl_q  <= led_ctrl_d;
            led_wdata_q <= led_wdata_d;
        end
    end

    assign io_busy   = (state_q != IDLE);
    assign led_ctrl  = led_ctrl_q;
    assign led_wdata = led_wdata_q;

    assign bus.rdata = (bus.mem_read && (bus.addr == LED_STAT_ADDR))
                       ? {30'b0, ovf_q, io_busy} : '0;

endmodule

// File: tb/tb_led_mmio_writer.sv
// tb_led_mmio_writer: directed then random stores/loads against a
// cycle-level reference model of the LED MMIO writer.
module tb_led_mmio_writer;
    import led_io_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        io_busy;
    logic        led_ctrl;
    logic [15:0] led_wdata;

    led_mmio_writer_if bus_if ();

    led_mmio_writer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .io_busy   (io_busy),
        .led_ctrl  (led_ctrl),
        .led_wdata (led_wdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: m_left = remaining busy cycles of a decimal store
    // (15 after acceptance), strobe seen in the last busy cycle.
    int          m_left = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    logic        m_ovf  = 1'b0;
    logic        m_ctrl = 1'b0;

    function automatic logic [15:0] to_bcd(input int unsigned v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check rdata pre-edge, advance the model,
    // then check the registered outputs just after the edge.
    task automatic step(input logic r, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] d);
        logic [31:0] exp_rd;
        logic        accept;
        rst              = r;
        bus_if.mem_write = we;
        bus_if.mem_read  = re;
        bus_if.addr      = a;
        bus_if.wdata     = d;
        #1;
        exp_rd = (re && a == LED_STAT_ADDR) ? {30'b0, m_ovf, (m_left > 0)} : 32'h0;
        check("rdata", bus_if.rdata, exp_rd);
        @(posedge clk);
        if (r) begin
            m_left = 0;
            m_disp = '0;
            m_ovf  = 1'b0;
            m_ctrl = 1'b0;
        end else begin
            accept = (m_left == 0) && we;
            m_ctrl = 1'b0;
            if (m_left > 0) begin
                if (m_left == 2) begin
                    m_ctrl = 1'b1;
                    m_disp = m_pend;
                end
                m_left--;
            end
            if (accept && a == LED_HEX_ADDR) begin
                m_disp = d[15:0];
                m_ctrl = 1'b1;
            end else if (accept && a == LED_DEC_ADDR) begin
                if (d > 32'd9999) begin
                    m_disp = 16'hEEEE;
                    m_ovf  = 1'b1;
                    m_ctrl = 1'b1;
                end else begin
                    m_ovf  = 1'b0;
                    m_pend = to_bcd(d);
                    m_left = 15;
                end
            end
        end
        #1;
        check("led_ctrl", {31'b0, led_ctrl}, {31'b0, m_ctrl});
        check("led_wdata", {16'b0, led_wdata}, {16'b0, m_disp});
        check("io_busy", {31'b0, io_busy}, {31'b0, (m_left > 0)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd_stat();
        step(1'b0, 1'b0, 1'b1, LED_STAT_ADDR, 32'h0);
    endtask

    initial begin
        logic        r, we, re;
        logic [31:0] a, d;

        // Reset
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("reset_wdata", {16'b0, led_wdata}, 32'h0);
        idle(1);

        // Hex store
        step(1'b0, 1'b1, 1'b0, LED_HEX_ADDR, 32'h0000_1234);
        check("hex_1234", {16'b0, led_wdata}, 32'h1234);
        idle(2);

        // Decimal 9999 with status read in N+5
        step(1'b0, 1'b1, 1'b0, LED_DEC_ADDR, 32'd9999);
        idle(4);
        rd_stat();
        check("stat_busy", bus_if.rdata, 32'h1);
        idle(9);
        check("dec_9999", {16'b0, led_wdata}, 32'h9999);
        idle(1);

        // Decimal 0, 255, 4096
        step(1'b0, 1'b1, 1'b0, LED_DEC_ADDR, 32'd0);
        idle(15);
        step(1'b0, 1'b1, 1'b0, LED_DEC_ADDR, 32'd255);
        idle(14);
        check("dec_255", {16'b0, led_wdata}, 32'h0255);
        idle(1);
        step(1'b0, 1'b1, 1'b0, LED_DEC_ADDR, 32'd4096);
        idle(14);
        check("dec_4096", {16'b0, led_wdata}, 32'h4096);
        idle(1);

        // Overflow, then cleared by a valid decimal store
        step(1'b0, 1'b1, 1'b0, LED_DEC_ADDR, 32'd10000);
        check("ovf_err", {16'b0, led_wdata}, 32'hEEEE);
        rd_stat();
        step(1'b0, 1'b1, 1'b0, LED_DEC_ADDR, 32'd42);
        idle(15);
        rd_stat();
        check("dec_42", {16'b0, led_wdata}, 32'h0042);

        // Stores while busy are dropped; N+16 is accepted
        step(1'b0, 1'b1, 1'b0, LED_DEC_ADDR, 32'd1234);
        idle(2);
        step(1'b0, 1'b1, 1'b0, LED_HEX_ADDR, 32'h0000_ABCD);
        idle(11);
        step(1'b0, 1'b1, 1'b0, LED_HEX_ADDR, 32'h0000_ABCD);
        check("drop_n15", {16'b0, led_wdata}, 32'h1234);
        step(1'b0, 1'b1, 1'b0, LED_HEX_ADDR, 32'h0000_ABCD);
        check("hex_n16", {16'b0, led_wdata}, 32'hABCD);
        idle(2);

        // Reset aborts a conversion
        step(1'b0, 1'b1, 1'b0, LED_DEC_ADDR, 32'd5678);
        idle(6);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("abort_wdata", {16'b0, led_wdata}, 32'h0);
        idle(10);
        rd_stat();
        step(1'b0, 1'b1, 1'b0, LED_HEX_ADDR, 32'h0000_0F0F);
        idle(1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(79) == 0);
            we = ($urandom_range(2) == 0);
            re = ($urandom_range(3) == 0);
            case ($urandom_range(4))
                0: a = LED_HEX_ADDR;
                1: a = LED_DEC_ADDR;
                2: a = LED_STAT_ADDR;
                3: a = LED_DEC_ADDR;
                default: a = $urandom;
            endcase
            case ($urandom_range(3))
                0: d = $urandom_range(9999);
                1: d = ($urandom_range(1) == 0) ? 32'd9999 : 32'd10000;
                2: d = $urandom;
                default: d = $urandom_range(20000);
            endcase
            step(r, we, re, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_mmio_writer.md
Name: led_mmio_writer

Overview:
- Memory-mapped I/O slave between the CPU data-memory bus and the 4-digit seven-segment scanner.
- Decodes CPU stores to the LED addresses and produces the scanner's one-cycle load strobe `led_ctrl` and its 16-bit digit word `led_wdata`.
- Hex mode passes the value straight through.
- Decimal mode runs a sequential shift-add-3 (double-dabble) conversion to 4 BCD digits before loading.
- A status register is readable so software can poll the busy and overflow flags.

Parameters:
- LED_HEX_ADDR, 32'hFFFF_FC60, store address for raw hex display.
- LED_DEC_ADDR, 32'hFFFF_FC64, store address for decimal display (binary in, BCD out).
- LED_STAT_ADDR, 32'hFFFF_FC68, load address of the status word.
- CONV_BITS, 14, binary width converted (covers 0..9999).
- ERR_PATTERN, 16'hEEEE, digit word shown on decimal overflow.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_write  in  1  CPU store strobe, one cycle per store
- mem_read  in  1  CPU load strobe
- addr  in  32  CPU byte address
- wdata  in  32  CPU store data
- rdata  out  32  load data; combinational
- io_busy  out  1  high while a decimal conversion is in progress
- led_ctrl  out  1  one-cycle load strobe to the scanner; registered
- led_wdata  out  16  digit word to the scanner, digit3..digit0 = [15:12]..[3:0]; registered, held between strobes

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst is synchronous and active-high.
  - On reset: state=IDLE, led_ctrl=0, led_wdata=16'h0000, io_busy=0, ovf=0, shift/BCD/count registers=0.
  - A reset during CONV or DONE aborts the conversion; no strobe is issued.
- States: IDLE, CONV, DONE. io_busy = (state != IDLE).
- Accepted store: mem_write=1 in IDLE with addr equal to LED_HEX_ADDR or LED_DEC_ADDR. Call the cycle of the store cycle N.
- Stores in CONV or DONE: dropped silently. No state change, no flag change.
- Stores to other addresses: ignored.
- Hex store:
  - led_wdata <= wdata[15:0] and led_ctrl=1 in cycle N+1.
  - State stays IDLE.
  - ovf is unchanged.
- Decimal store with wdata > 9999 (full 32 bits compared):
  - led_wdata <= ERR_PATTERN and led_ctrl=1 in cycle N+1.
  - ovf <= 1.
  - State stays IDLE.
- Decimal store with wdata <= 9999:
  - Load bin <= wdata[CONV_BITS-1:0], bcd <= 0, cnt <= 0.
  - ovf <= 0.
  - state <= CONV.
- CONV, one iteration per cycle:
  - Each BCD digit >= 5 gets +3.
  - Then {bcd,bin} shifts left by 1.
  - After CONV_BITS iterations (cycles N+1..N+14) the state moves to DONE.
- DONE, in cycle N+15:
  - led_ctrl=1 and led_wdata=bcd.
  - Next cycle: IDLE.
  - Total: busy for 15 cycles; a store in N+16 is accepted.
- led_ctrl is high for exactly one cycle per accepted store. It never asserts twice for one store.
- led_wdata only changes together with a led_ctrl pulse or on reset.
- Reads:
  - mem_read=1 with addr==LED_STAT_ADDR gives rdata={30'b0, ovf, io_busy}.
  - Otherwise rdata=32'h0.
  - Reads have no side effects.
- A read and a store in the same cycle: both are processed independently. rdata reflects pre-edge state.

Decomposition:
- Package led_io_pkg holds:
  - the address constants;
  - DEC_MAX=9999;
  - ERR_PATTERN;
  - CONV_BITS;
  - the state enum {IDLE, CONV, DONE}.
- One combinational sub-module, bcd_dabble_step: inputs bcd[15:0] and bin_msb; output is the next bcd[15:0] (add-3 correction, then shift). It is instanced once in the CONV datapath.

Test Plan:
- Reset, then hex store 32'h0000_1234 in cycle N → led_ctrl=1 only in N+1, led_wdata=16'h1234, io_busy stays 0.
- Decimal store 9999 in N → io_busy=1 in N+1..N+15; led_ctrl=1 only in N+15 with led_wdata=16'h9999; read of LED_STAT_ADDR during N+5 gives 32'h1.
- Decimal stores 0, 255 and 4096 → strobes with 16'h0000, 16'h0255 and 16'h4096, each 15 cycles after its store.
- Decimal store 10000 → led_ctrl in N+1 with 16'hEEEE, status read gives 32'h2; a following decimal store of 42 clears ovf (status 32'h0 after the strobe) and shows 16'h0042.
- Decimal store 1234, then hex store 16'hABCD in N+3 and again in N+15 → both hex stores dropped; a single strobe with 16'h1234; a hex store in N+16 is accepted and strobes 16'hABCD in N+17.
- Decimal store 5678, with rst asserted in N+7 → no led_ctrl pulse; led_wdata=16'h0000, io_busy=0 and ovf=0 from N+8 on; a hex store afterwards works normally.
